// File: rtl/sclkfifo_rr_sched_pkg.sv
// Shared types and sizing for the packet round-robin FIFO drain scheduler.
package sclkfifo_rr_sched_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/sclkfifo_rr_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1, wrapping.
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int IW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IW-1:0]        idx,
    output logic                 any
);

    logic [2*NUM_PORTS-1:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [IW:0]            sh;
    logic [IW:0]            first;
    logic [IW+1:0]          sum;

    // Bit j of rot is port (ptr+1+j) mod NUM_PORTS, so the lowest set bit wins.
    assign dbl = {req, req};
    assign sh  = {1'b0, ptr} + (IW+1)'(1);
    assign rot = NUM_PORTS'(dbl >> sh);

    always_comb begin
        first = '0;
        any   = 1'b0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                first = (IW+1)'(j);
                any   = 1'b1;
            end
        end
        sum = {1'b0, sh} + {1'b0, first};
        if (sum >= (IW+2)'(NUM_PORTS))
            sum = sum - (IW+2)'(NUM_PORTS);
        idx      = sum[IW-1:0];
        gnt      = '0;
        gnt[idx] = any;
    end

endmodule

// File: rtl/sclkfifo_rr_sched.sv
// Packet-level round-robin drain of NUM_PORTS registered-read FIFOs into a 2-entry
// valid/ready output buffer; a grant is held until the EOP word comes back.
module sclkfifo_rr_sched
    import sclkfifo_rr_sched_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic [NUM_PORTS-1:0]            port_en,
    input  logic [NUM_PORTS-1:0]            fifo_rempty,
    output logic [NUM_PORTS-1:0]            fifo_ren,
    input  logic [NUM_PORTS*FIFO_WIDTH-1:0] fifo_rdata,
    output logic                            out_valid,
    output logic [FIFO_WIDTH-1:0]           out_data,
    input  logic                            out_ready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t                state;
    logic [IW-1:0]         ptr;
    logic                  rd_vld_q;
    logic [FIFO_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic                  head;
    logic [CNT_W-1:0]      count;

    logic [NUM_PORTS-1:0]  arb_gnt;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;
    logic [FIFO_WIDTH-1:0] rdata_g;
    logic [CNT_W:0]        occ;
    logic                  pop, push, space, eop_ret, ren_ok;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req (port_en & ~fifo_rempty),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // ptr always equals the granted port while LOCKED, so it doubles as the read mux select.
    assign rdata_g   = fifo_rdata[int'(ptr)*FIFO_WIDTH +: FIFO_WIDTH];
    assign out_valid = (count != '0);
    assign out_data  = buf_mem[head];
    assign pop       = out_valid & out_ready;
    assign push      = rd_vld_q;

    // Occupancy counts the word still in flight from the FIFO so the buffer can never overrun.
    assign occ      = {1'b0, count} + (CNT_W+1)'(rd_vld_q) - (CNT_W+1)'(pop);
    assign space    = (occ < (CNT_W+1)'(BUF_DEPTH));
    assign eop_ret  = rd_vld_q & rdata_g[FIFO_WIDTH-1];
    assign ren_ok   = (state == S_LOCKED) & ~fifo_rempty[ptr] & space & ~eop_ret;
    assign fifo_ren = ren_ok ? grant : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
            grant <= '0;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        state <= S_LOCKED;
                        grant <= arb_gnt;
                        ptr   <= arb_idx;
                        busy  <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (eop_ret) begin
                        state <= S_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_vld_q <= 1'b0;
            head     <= 1'b0;
            count    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                buf_mem[i] <= '0;
        end else begin
            rd_vld_q <= |fifo_ren;
            if (push)
                buf_mem[head ^ count[0]] <= rdata_g;
            if (pop)
                head <= ~head;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
